// File: rtl/dbg_uart_tx_arbiter.sv
// dbg_uart_tx_arbiter
// Shares one debug UART transmitter between N_REQ byte streams with
// packet-granular round-robin arbitration. Each packet is framed as
// START_BYTE, optional source-ID digit, payload, CR, LF. A watchdog closes
// the frame if the owning requester goes quiet for TIMEOUT cycles.
// Optional feature macro: ARB_SRC_ID_EN (adds the ASCII source-ID byte).
module dbg_uart_tx_arbiter #(
  parameter int          N_REQ      = 4,
  parameter logic [7:0]  START_BYTE = 8'h2D,
  parameter logic [31:0] TIMEOUT    = 32'h0000_0FFF
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [8*N_REQ-1:0] i_req_data,
  input  logic [N_REQ-1:0]   i_req_valid,
  input  logic [N_REQ-1:0]   i_req_last,
  output logic [N_REQ-1:0]   o_req_ready,
  input  logic               i_wready,
  output logic [7:0]         o_wdata,
  output logic               o_wvalid,
  output logic [N_REQ-1:0]   o_grant,
  output logic               o_busy,
  output logic               o_abort
);
  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_ID,
    S_DATA,
    S_CR,
    S_LF
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [IDX_W-1:0] r_gidx;
  logic [IDX_W-1:0] r_last_grant;
  logic [N_REQ-1:0] r_grant;
  logic [31:0]      r_wdog;
  logic [IDX_W-1:0] w_pick_idx;
  logic             w_pick_found;
  logic [7:0]       w_g_data;
  logic             w_g_valid;
  logic             w_g_last;
  logic             w_xfer;

  // Byte lane of the current owner, used for the zero-latency payload path.
  assign w_g_data  = i_req_data[{r_gidx, 3'b000} +: 8];
  assign w_g_valid = i_req_valid[r_gidx];
  assign w_g_last  = i_req_last[r_gidx];

  assign o_grant = r_grant;
  assign o_busy  = (r_state != S_IDLE);

  // Only the owner sees ready, and only while its payload is being streamed.
  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_ready
    assign o_req_ready[gi] = (r_state == S_DATA) && r_grant[gi] && i_wready;
  end

  // Round-robin scan of pending requests starting just after the last owner.
  always_comb begin
    int w_sum;
    w_pick_found = 1'b0;
    w_pick_idx   = r_last_grant;
    w_sum        = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      w_sum = int'(r_last_grant) + k;
      if (w_sum >= N_REQ) w_sum = w_sum - N_REQ;
      if (!w_pick_found && i_req_valid[w_sum[IDX_W-1:0]]) begin
        w_pick_found = 1'b1;
        w_pick_idx   = w_sum[IDX_W-1:0];
      end
    end
  end

  // Next-state and UART-side outputs; framing bytes hold until accepted.
  always_comb begin
    w_state_next = r_state;
    o_wdata      = 8'h00;
    o_wvalid     = 1'b0;
    o_abort      = 1'b0;
    w_xfer       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_pick_found) w_state_next = S_START;
      end
      S_START: begin
        o_wdata  = START_BYTE;
        o_wvalid = 1'b1;
`ifdef ARB_SRC_ID_EN
        if (i_wready) w_state_next = S_ID;
`else
        if (i_wready) w_state_next = S_DATA;
`endif
      end
      S_ID: begin
        o_wdata  = 8'h30 + 8'(r_gidx);
        o_wvalid = 1'b1;
        if (i_wready) w_state_next = S_DATA;
      end
      S_DATA: begin
        o_wdata  = w_g_data;
        o_wvalid = w_g_valid;
        w_xfer   = w_g_valid && i_wready;
        // A real transfer wins over an expiring watchdog in the same cycle.
        if (w_xfer) begin
          if (w_g_last) w_state_next = S_CR;
        end else if (r_wdog == TIMEOUT) begin
          o_abort      = 1'b1;
          w_state_next = S_CR;
        end
      end
      S_CR: begin
        o_wdata  = 8'h0D;
        o_wvalid = 1'b1;
        if (i_wready) w_state_next = S_LF;
      end
      S_LF: begin
        o_wdata  = 8'h0A;
        o_wvalid = 1'b1;
        if (i_wready) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  // Ownership: latched on the IDLE decision, released after the LF byte.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_grant      <= '0;
      r_gidx       <= '0;
      r_last_grant <= IDX_W'(N_REQ - 1);
    end else if (r_state == S_IDLE && w_pick_found) begin
      r_grant      <= {{(N_REQ-1){1'b0}}, 1'b1} << w_pick_idx;
      r_gidx       <= w_pick_idx;
      r_last_grant <= w_pick_idx;
    end else if (r_state == S_LF && i_wready) begin
      r_grant <= '0;
    end
  end

  // Watchdog counts owner-idle payload cycles; backpressure does not count.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)                  r_wdog <= '0;
    else if (r_state != S_DATA) r_wdog <= '0;
    else if (w_xfer)            r_wdog <= '0;
    else if (!w_g_valid)        r_wdog <= r_wdog + 32'd1;
  end

endmodule

// File: tb/tb_dbg_uart_tx_arbiter.sv
// Testbench for dbg_uart_tx_arbiter: directed scenarios plus a random phase,
// checked cycle by cycle against a packet-level reference model.
`timescale 1ns/1ps
module tb_dbg_uart_tx_arbiter;
  localparam int N     = 4;
  localparam int TMO   = 32'h0000_0FFF;
  localparam int DEPTH = 256;

  logic           clk = 1'b0;
  logic           rst;
  logic [8*N-1:0] req_data;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_last;
  logic [N-1:0]   req_ready;
  logic           wready;
  logic [7:0]     wdata;
  logic           wvalid;
  logic [N-1:0]   grant;
  logic           busy;
  logic           abort_p;

  dbg_uart_tx_arbiter #(
    .N_REQ(N), .START_BYTE(8'h2D), .TIMEOUT(32'h0000_0FFF)
  ) dut (
    .i_clk(clk), .i_rst(rst),
    .i_req_data(req_data), .i_req_valid(req_valid), .i_req_last(req_last),
    .o_req_ready(req_ready), .i_wready(wready), .o_wdata(wdata),
    .o_wvalid(wvalid), .o_grant(grant), .o_busy(busy), .o_abort(abort_p)
  );

  always #5 clk = ~clk;

  // Requester byte stores (each requester streams its bytes in order).
  logic [7:0] st_data [N][DEPTH];
  logic       st_last [N][DEPTH];
  int wr_p [N];
  int rd_p [N];
  int pkt_p[N];
  int gap_pct, wr_pct, wr_pat, pat_cnt;

  // Reference model: stage 0 idle, 1 header, 2 payload, 3 CR/LF trailer.
  int m_stage, m_owner, m_last, m_wd;
  logic [7:0] exp_q[$];
  logic [7:0] byte_log[$];
  int grant_log[$];
  logic [N-1:0] prev_g;
  int total, bad, n_abort_seen;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_byte(input int k, input logic [7:0] d, input logic l);
    st_data[k][wr_p[k]] = d;
    st_last[k][wr_p[k]] = l;
    wr_p[k]++;
  endtask

  function automatic bit all_empty();
    bit e;
    e = 1'b1;
    for (int k = 0; k < N; k++) if (rd_p[k] != wr_p[k]) e = 1'b0;
    return e;
  endfunction

  task automatic drive();
    for (int k = 0; k < N; k++) begin
      bit has;
      has = (rd_p[k] < wr_p[k]);
      req_valid[k]       = has && ($urandom_range(99) >= gap_pct);
      req_data[8*k +: 8] = has ? st_data[k][rd_p[k]] : 8'h00;
      req_last[k]        = has ? st_last[k][rd_p[k]] : 1'b0;
    end
    if (wr_pat != 0) wready = (pat_cnt % 4 == 0) || (pat_cnt % 4 == 3);
    else             wready = ($urandom_range(99) < wr_pct);
    pat_cnt++;
  endtask

  task automatic reset_model();
    m_stage = 0;
    m_owner = -1;
    m_last  = N - 1;
    m_wd    = 0;
    exp_q.delete();
    prev_g  = '0;
    for (int k = 0; k < N; k++) rd_p[k] = pkt_p[k];
  endtask

  // One clock of expected behaviour, evaluated on the falling edge.
  task automatic model_cycle();
    logic [31:0] er;
    logic        ea;
    int          own;
    own = m_owner;
    ea  = 1'b0;
    er  = '0;
    if (m_stage == 2 && wready) er[own] = 1'b1;
    chk("grant", 32'(grant), (own >= 0) ? (32'd1 << own) : 32'd0);
    chk("busy", 32'(busy), 32'(own >= 0));
    chk("ready", 32'(req_ready), er);
    case (m_stage)
      0: begin
        int pick;
        pick = -1;
        chk("idle_wvalid", 32'(wvalid), 32'd0);
        for (int j = 1; j <= N; j++) begin
          int idx;
          idx = (m_last + j) % N;
          if (pick < 0 && req_valid[idx]) pick = idx;
        end
        if (pick >= 0) begin
          m_owner = pick;
          m_last  = pick;
          m_stage = 1;
          exp_q.push_back(8'h2D);
`ifdef ARB_SRC_ID_EN
          exp_q.push_back(8'h30 + 8'(pick));
`endif
        end
      end
      1, 3: begin
        chk("frame_wvalid", 32'(wvalid), 32'd1);
        chk("frame_wdata", 32'(wdata), 32'(exp_q[0]));
        if (wready) begin
          void'(exp_q.pop_front());
          if (exp_q.size() == 0) begin
            if (m_stage == 1) begin
              m_stage = 2;
              m_wd    = 0;
            end else begin
              m_stage = 0;
              m_owner = -1;
            end
          end
        end
      end
      default: begin
        chk("data_wvalid", 32'(wvalid), 32'(req_valid[own]));
        if (req_valid[own]) chk("data_wdata", 32'(wdata), 32'(st_data[own][rd_p[own]]));
        if (req_valid[own] && wready) begin
          m_wd = 0;
          if (st_last[own][rd_p[own]]) begin
            m_stage = 3;
            exp_q.push_back(8'h0D);
            exp_q.push_back(8'h0A);
          end
        end else if (m_wd == TMO) begin
          ea      = 1'b1;
          m_stage = 3;
          exp_q.push_back(8'h0D);
          exp_q.push_back(8'h0A);
        end else if (!req_valid[own]) begin
          m_wd++;
        end
      end
    endcase
    chk("abort", 32'(abort_p), 32'(ea));
  endtask

  task automatic step();
    bit pop[N];
    @(negedge clk);
    if (rst) begin
      chk("rst_wvalid", 32'(wvalid), 32'd0);
      chk("rst_wdata", 32'(wdata), 32'd0);
      chk("rst_grant", 32'(grant), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_abort", 32'(abort_p), 32'd0);
      chk("rst_ready", 32'(req_ready), 32'd0);
    end else begin
      model_cycle();
      if (wvalid && wready) byte_log.push_back(wdata);
      if (abort_p) n_abort_seen++;
      if (grant != 0 && prev_g == 0)
        for (int k = 0; k < N; k++) if (grant[k]) grant_log.push_back(k);
      prev_g = grant;
    end
    for (int k = 0; k < N; k++) pop[k] = !rst && req_ready[k] && req_valid[k];
    @(posedge clk);
    for (int k = 0; k < N; k++)
      if (pop[k]) begin
        if (st_last[k][rd_p[k]]) pkt_p[k] = rd_p[k] + 1;
        rd_p[k]++;
      end
    #1 drive();
  endtask

  task automatic drain(input int budget, input string tag);
    bit done;
    done = 1'b0;
    for (int c = 0; c < budget && !done; c++) begin
      step();
      done = (m_stage == 0) && all_empty();
    end
    chk(tag, 32'(done), 32'd1);
  endtask

  initial begin
    logic [7:0] e[$];
    int s;
    total = 0; bad = 0; n_abort_seen = 0;
    gap_pct = 0; wr_pct = 100; wr_pat = 0; pat_cnt = 0;
    for (int k = 0; k < N; k++) begin wr_p[k] = 0; rd_p[k] = 0; pkt_p[k] = 0; end
    rst = 1'b1; req_valid = '0; req_data = '0; req_last = '0; wready = 1'b0;
    reset_model();
    step();
    step();
    rst = 1'b0;
    reset_model();

    // Single packet from req0 with the UART always ready.
    push_byte(0, 8'h41, 1'b0);
    push_byte(0, 8'h42, 1'b1);
    drive();
    byte_log.delete();
    drain(50, "t1_drain");
    e = {8'h2D};
`ifdef ARB_SRC_ID_EN
    e.push_back(8'h30);
`endif
    e.push_back(8'h41); e.push_back(8'h42); e.push_back(8'h0D); e.push_back(8'h0A);
    chk("t1_len", 32'(byte_log.size()), 32'(e.size()));
    for (int i = 0; i < e.size() && i < byte_log.size(); i++) chk("t1_byte", 32'(byte_log[i]), 32'(e[i]));

    // Round-robin among req0, req2, req3; req0 owned last, so order is 2,3,0,...
    s = grant_log.size();
    for (int r = 0; r < 2; r++) begin
      push_byte(0, 8'hA0 + 8'(r), 1'b1);
      push_byte(2, 8'hB0 + 8'(r), 1'b1);
      push_byte(3, 8'hC0 + 8'(r), 1'b1);
    end
    drive();
    drain(200, "t2_drain");
    e = {8'd2, 8'd3, 8'd0, 8'd2, 8'd3, 8'd0};
    chk("t2_ngrants", 32'(grant_log.size() - s), 32'd6);
    for (int i = 0; i < 6 && s + i < grant_log.size(); i++) chk("t2_order", 32'(grant_log[s+i]), 32'(e[i]));

    // Backpressure: wready follows 1,0,0,1.
    wr_pat = 1; pat_cnt = 0;
    push_byte(1, 8'h11, 1'b0); push_byte(1, 8'h22, 1'b0); push_byte(1, 8'h33, 1'b1);
    drive();
    drain(200, "t3_drain");
    wr_pat = 0;

    // Timeout: req1 sends 0x55 then goes silent; req2 waits its turn.
    s = grant_log.size();
    n_abort_seen = 0;
    push_byte(1, 8'h55, 1'b0);
    drive();
    for (int i = 0; i < 6; i++) step();
    push_byte(2, 8'h77, 1'b1);
    drive();
    drain(TMO + 300, "t4_drain");
    chk("t4_aborts", 32'(n_abort_seen), 32'd1);
    chk("t4_ngrants", 32'(grant_log.size() - s), 32'd2);
    if (grant_log.size() >= s + 2) begin
      chk("t4_first", 32'(grant_log[s]), 32'd1);
      chk("t4_next", 32'(grant_log[s+1]), 32'd2);
    end
    push_byte(1, 8'h56, 1'b1);
    drive();
    drain(100, "t4_tail");

    // Asynchronous reset while req3 streams payload; req1 also pending.
    for (int i = 0; i < 5; i++) push_byte(3, 8'hD0 + 8'(i), i == 4);
    push_byte(1, 8'hE0, 1'b0); push_byte(1, 8'hE1, 1'b1);
    drive();
    for (int c = 0; c < 50 && !(m_stage == 2 && rd_p[3] > pkt_p[3]); c++) step();
    chk("t5_in_data", 32'(m_stage), 32'd2);
    #2 rst = 1'b1;
    #1;
    chk("t5_wvalid", 32'(wvalid), 32'd0);
    chk("t5_grant", 32'(grant), 32'd0);
    chk("t5_busy", 32'(busy), 32'd0);
    reset_model();
    drive();
    step();
    rst = 1'b0;
    s = grant_log.size();
    drain(300, "t5_drain");
    if (grant_log.size() > s) chk("t5_first_grant", 32'(grant_log[s]), 32'd1);
    else chk("t5_any_grant", 32'(grant_log.size()), 32'(s + 1));

    // Random packets, random gaps and random backpressure.
    gap_pct = 25; wr_pct = 70;
    for (int p = 0; p < 40; p++) begin
      int k, len;
      k   = $urandom_range(N - 1);
      len = $urandom_range(5, 1);
      for (int b = 0; b < len; b++) push_byte(k, 8'($urandom), b == len - 1);
    end
    drive();
    drain(20000, "t6_drain");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
